tape_access_ctrl: RTL and testbench

Sequencer and arbiter in front of `tape_memory`. It owns the data pointer and turns single-cycle core tape commands into correctly timed memory accesses: pointer moves, read-modify-write of the cell for `+`/`-`, cell store for `,`, and cell read for `.`/`[`/`]`. It also shares the memory's single read/write pair between the execution core and a debug/host read port using round-robin arbitration.

---
 rtl/tinybf_pkg.sv | 29 ++
 rtl/tape_rr_arbiter.sv | 32 +++
 rtl/tape_access_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_tape_access_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinybf_pkg.sv
// Shared encodings for the tape access path: core command opcodes and
// the access controller's sequencer states.
package tinybf_pkg;

    typedef enum logic [2:0] {
        OP_PTR_INC  = 3'd0,
        OP_PTR_DEC  = 3'd1,
        OP_CELL_INC = 3'd2,
        OP_CELL_DEC = 3'd3,
        OP_CELL_WR  = 3'd4,
        OP_CELL_RD  = 3'd5,
        OP_NOP      = 3'd6
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_MOD  = 3'd2,
        ST_WR   = 3'd3,
        ST_DRD  = 3'd4,
        ST_DCAP = 3'd5
    } state_e;

    // Ops that need a read of the current cell before responding.
    function automatic logic needs_read(input logic [2:0] op);
        return (op == OP_CELL_INC) || (op == OP_CELL_DEC) || (op == OP_CELL_RD);
    endfunction

endpackage

// File: rtl/tape_rr_arbiter.sv
// Two-requester round-robin arbiter. Requester 0 is the core, requester 1 the
// debug port; on contention the one not granted last wins.
module tape_rr_arbiter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    // 1 means the debug requester held the most recent grant.
    logic last_gnt_q;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            gnt[0] = req[0] & (~req[1] | last_gnt_q);
            gnt[1] = req[1] & (~req[0] | ~last_gnt_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_gnt_q <= 1'b1;
        end else if (gnt[0]) begin
            last_gnt_q <= 1'b0;
        end else if (gnt[1]) begin
            last_gnt_q <= 1'b1;
        end
    end

endmodule

// File: rtl/tape_access_ctrl.sv
// Tape access sequencer: owns the data pointer, turns core tape commands into
// timed accesses on a 1-cycle-latency memory, and shares it with a debug reader.
module tape_access_ctrl
    import tinybf_pkg::*;
#(
    parameter int CELL_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // Handshake: a command/debug request transfers on the rising edge where
    // valid (or req) and ready (or gnt) are both high; ready/gnt are only
    // offered in IDLE and never depend on anything but state and requests.
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic [CELL_W-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    output logic [CELL_W-1:0] rsp_data_o,
    output logic              rsp_zero_o,
    output logic [AW-1:0]     ptr_o,
    input  logic              dbg_req_i,
    input  logic [AW-1:0]     dbg_addr_i,
    output logic              dbg_gnt_o,
    output logic              dbg_valid_o,
    output logic [CELL_W-1:0] dbg_data_o,
    output logic              mem_ren_o,
    output logic [AW-1:0]     mem_raddr_o,
    input  logic [CELL_W-1:0] mem_rdata_i,
    output logic              mem_wen_o,
    output logic [AW-1:0]     mem_waddr_o,
    output logic [CELL_W-1:0] mem_wdata_o,
    output state_e            state_o
);

    state_e            state_q, state_d;
    logic [AW-1:0]     ptr_q;
    logic [2:0]        op_q;
    logic [CELL_W-1:0] data_q;
    logic [AW-1:0]     dbg_addr_q;
    logic              rsp_valid_q;
    logic [CELL_W-1:0] rsp_data_q;
    logic              dbg_valid_q;
    logic [CELL_W-1:0] dbg_data_q;
    logic [CELL_W-1:0] new_val;
    logic [1:0]        gnt;
    logic              core_gnt;
    logic              dbg_gnt;

    tape_rr_arbiter u_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req    ({dbg_req_i, cmd_valid_i}),
        .enable (state_q == ST_IDLE),
        .gnt    (gnt)
    );

    assign core_gnt    = gnt[0];
    assign dbg_gnt     = gnt[1];
    assign cmd_ready_o = core_gnt;
    assign dbg_gnt_o   = dbg_gnt;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_zero_o  = (rsp_data_q == '0);
    assign ptr_o       = ptr_q;
    assign dbg_valid_o = dbg_valid_q;
    assign dbg_data_o  = dbg_data_q;
    assign state_o     = state_q;

    always_comb begin
        new_val = mem_rdata_i;
        if (op_q == OP_CELL_INC) begin
            new_val = mem_rdata_i + CELL_W'(1);
        end else if (op_q == OP_CELL_DEC) begin
            new_val = mem_rdata_i - CELL_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_ren_o   = 1'b0;
        mem_raddr_o = '0;
        mem_wen_o   = 1'b0;
        mem_waddr_o = '0;
        mem_wdata_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (core_gnt) begin
                    if (needs_read(cmd_op_i)) begin
                        state_d = ST_RD;
                    end else if (cmd_op_i == OP_CELL_WR) begin
                        state_d = ST_WR;
                    end
                end else if (dbg_gnt) begin
                    state_d = ST_DRD;
                end
            end
            ST_RD: begin
                mem_ren_o   = 1'b1;
                mem_raddr_o = ptr_q;
                state_d     = ST_MOD;
            end
            ST_MOD: begin
                // CELL_RD only reports the cell, no write-back.
                if (op_q != OP_CELL_RD) begin
                    mem_wen_o   = 1'b1;
                    mem_waddr_o = ptr_q;
                    mem_wdata_o = new_val;
                end
                state_d = ST_IDLE;
            end
            ST_WR: begin
                mem_wen_o   = 1'b1;
                mem_waddr_o = ptr_q;
                mem_wdata_o = data_q;
                state_d     = ST_IDLE;
            end
            ST_DRD: begin
                mem_ren_o   = 1'b1;
                mem_raddr_o = dbg_addr_q;
                state_d     = ST_DCAP;
            end
            ST_DCAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            op_q        <= OP_NOP;
            data_q      <= '0;
            dbg_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            dbg_valid_q <= 1'b0;
            dbg_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
            dbg_valid_q <= 1'b0;
            if (core_gnt) begin
                op_q   <= cmd_op_i;
                data_q <= cmd_data_i;
                case (cmd_op_i)
                    OP_PTR_INC: begin
                        ptr_q       <= ptr_q + AW'(1);
                        rsp_valid_q <= 1'b1;
                    end
                    OP_PTR_DEC: begin
                        ptr_q       <= ptr_q - AW'(1);
                        rsp_valid_q <= 1'b1;
                    end
                    OP_CELL_INC, OP_CELL_DEC, OP_CELL_WR, OP_CELL_RD: begin
                        rsp_valid_q <= 1'b0;
                    end
                    default: begin
                        rsp_valid_q <= 1'b1;
                    end
                endcase
            end
            if (dbg_gnt) begin
                dbg_addr_q <= dbg_addr_i;
            end
            case (state_q)
                ST_MOD: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= new_val;
                end
                ST_WR: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= data_q;
                end
                ST_DCAP: begin
                    dbg_valid_q <= 1'b1;
                    dbg_data_q  <= mem_rdata_i;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tape_access_ctrl.sv
// Directed bench for tape_access_ctrl with a behavioural 1-cycle-latency tape
// memory attached to the memory port.
module tb_tape_access_ctrl;
    import tinybf_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic [3:0] ptr;
    logic       dbg_req;
    logic [3:0] dbg_addr;
    logic       dbg_gnt;
    logic       dbg_valid;
    logic [7:0] dbg_data;
    logic       mem_ren;
    logic [3:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic       mem_wen;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;
    state_e     state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [16] = '{default: 8'h00};
    logic [7:0] exp_q [$];

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic [7:0] exp_rsp;
        logic       exp_zero;
        logic [3:0] exp_ptr;
        logic [7:0] exp_cell;
        int         exp_lat;
    } vec_t;

    vec_t vecs [14];

    tape_access_ctrl #(.CELL_W(8), .DEPTH(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_zero_o  (rsp_zero),
        .ptr_o       (ptr),
        .dbg_req_i   (dbg_req),
        .dbg_addr_i  (dbg_addr),
        .dbg_gnt_o   (dbg_gnt),
        .dbg_valid_o (dbg_valid),
        .dbg_data_o  (dbg_data),
        .mem_ren_o   (mem_ren),
        .mem_raddr_o (mem_raddr),
        .mem_rdata_i (mem_rdata),
        .mem_wen_o   (mem_wen),
        .mem_waddr_o (mem_waddr),
        .mem_wdata_o (mem_wdata),
        .state_o     (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tape memory model
    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_raddr];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (mem_ren && mem_wen) begin
                n_fail++;
                $display("FAIL mem_excl: ren=%0b wen=%0b both high", mem_ren, mem_wen);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Driver: issue one command, wait for its response and check it.
    task automatic do_cmd(input vec_t v, input int idx);
        bit acc;
        int lat;
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_data  = v.data;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = 8'hA5;
        check($sformatf("v%0d.accept", idx), 32'(acc), 32'd1);
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (rsp_valid) lat = i;
        end
        check($sformatf("v%0d.latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d.rsp_data", idx), 32'(rsp_data), 32'(v.exp_rsp));
        check($sformatf("v%0d.rsp_zero", idx), 32'(rsp_zero), 32'(v.exp_zero));
        check($sformatf("v%0d.ptr", idx), 32'(ptr), 32'(v.exp_ptr));
        check($sformatf("v%0d.cell", idx), 32'(mem[v.exp_ptr]), 32'(v.exp_cell));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit         g_core, g_dbg;
        int         core_n, dbg_n, dbg_seen, grants, lat;
        logic [3:0] ord;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = 8'h00;
        dbg_req   = 1'b0;
        dbg_addr  = 4'd0;

        //             op           data   rsp    zero  ptr    cell   lat
        vecs[0]  = '{OP_CELL_INC, 8'h00, 8'h01, 1'b0, 4'd0,  8'h01, 3};
        vecs[1]  = '{OP_CELL_INC, 8'h00, 8'h02, 1'b0, 4'd0,  8'h02, 3};
        vecs[2]  = '{OP_CELL_INC, 8'h00, 8'h03, 1'b0, 4'd0,  8'h03, 3};
        vecs[3]  = '{OP_CELL_RD,  8'h00, 8'h03, 1'b0, 4'd0,  8'h03, 3};
        vecs[4]  = '{OP_PTR_DEC,  8'h00, 8'h03, 1'b0, 4'd15, 8'h00, 1};
        vecs[5]  = '{OP_CELL_DEC, 8'h00, 8'hFF, 1'b0, 4'd15, 8'hFF, 3};
        vecs[6]  = '{OP_PTR_INC,  8'h00, 8'hFF, 1'b0, 4'd0,  8'h03, 1};
        vecs[7]  = '{OP_CELL_WR,  8'hFF, 8'hFF, 1'b0, 4'd0,  8'hFF, 2};
        vecs[8]  = '{OP_CELL_INC, 8'h00, 8'h00, 1'b1, 4'd0,  8'h00, 3};
        vecs[9]  = '{OP_NOP,      8'h00, 8'h00, 1'b1, 4'd0,  8'h00, 1};
        vecs[10] = '{OP_CELL_WR,  8'h5A, 8'h5A, 1'b0, 4'd0,  8'h5A, 2};
        vecs[11] = '{OP_PTR_INC,  8'h00, 8'h5A, 1'b0, 4'd1,  8'h00, 1};
        vecs[12] = '{OP_CELL_DEC, 8'h00, 8'hFF, 1'b0, 4'd1,  8'hFF, 3};
        vecs[13] = '{3'd7,        8'h00, 8'hFF, 1'b0, 4'd1,  8'hFF, 1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.state", 32'(state), 32'(ST_IDLE));
        check("rst.ptr", 32'(ptr), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_data", 32'(rsp_data), 32'd0);
        check("rst.rsp_zero", 32'(rsp_zero), 32'd1);
        check("rst.dbg_valid", 32'(dbg_valid), 32'd0);
        check("rst.dbg_data", 32'(dbg_data), 32'd0);
        check("rst.mem_ctl", 32'({mem_ren, mem_wen}), 32'd0);
        check("rst.mem_bus", 32'({mem_raddr, mem_waddr, mem_wdata}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle.ready", 32'({cmd_ready, dbg_gnt}), 32'd0);
        @(posedge clk);
        #1;

        // Table-driven command sequence
        for (int i = 0; i < 14; i++) do_cmd(vecs[i], i);
        check("mem15", 32'(mem[15]), 32'hFF);

        // Debug read latency
        dbg_req  = 1'b1;
        dbg_addr = 4'd15;
        @(negedge clk);
        check("dbg.gnt", 32'(dbg_gnt), 32'd1);
        @(posedge clk);
        #1;
        dbg_req  = 1'b0;
        dbg_addr = 4'd3;
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (dbg_valid) lat = i;
        end
        check("dbg.latency", 32'(lat), 32'd3);
        check("dbg.data", 32'(dbg_data), 32'hFF);
        @(posedge clk);
        #1;

        // Contention: core wins first after reset, then grants alternate
        apply_reset();
        cmd_valid = 1'b1;
        cmd_op    = OP_CELL_WR;
        cmd_data  = 8'h11;
        dbg_req   = 1'b1;
        dbg_addr  = 4'd0;
        core_n = 0; dbg_n = 0; dbg_seen = 0; grants = 0; ord = 4'b0000;
        for (int cyc = 0; cyc < 40 && dbg_seen < 2; cyc++) begin
            @(negedge clk);
            g_core = cmd_ready;
            g_dbg  = dbg_gnt;
            if (g_core && g_dbg) check("arb.exclusive", 32'd1, 32'd0);
            if (dbg_valid) begin
                dbg_seen++;
                if (exp_q.size() == 0) begin
                    check("arb.dbg_unexpected", 32'(dbg_data), 32'hFFFF);
                end else begin
                    check($sformatf("arb.dbg_data%0d", dbg_seen), 32'(dbg_data), 32'(exp_q.pop_front()));
                end
            end
            @(posedge clk);
            #1;
            if (g_core) begin
                ord = {ord[2:0], 1'b0};
                grants++;
                core_n++;
                exp_q.push_back(cmd_data);
                cmd_data = 8'h22;
                if (core_n == 2) cmd_valid = 1'b0;
            end
            if (g_dbg) begin
                ord = {ord[2:0], 1'b1};
                grants++;
                dbg_n++;
                if (dbg_n == 2) dbg_req = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        dbg_req   = 1'b0;
        check("arb.grants", 32'(grants), 32'd4);
        check("arb.order", 32'(ord), 32'b0101);
        check("arb.dbg_count", 32'(dbg_seen), 32'd2);
        check("arb.mem0", 32'(mem[0]), 32'h22);

        // Back-to-back PTR_INC x17
        apply_reset();
        cmd_valid = 1'b1;
        cmd_op    = OP_PTR_INC;
        @(negedge clk);
        check("b2b.ready0", 32'(cmd_ready), 32'd1);
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            if (i == 17) cmd_valid = 1'b0;
            @(negedge clk);
            check($sformatf("b2b.rsp%0d", i), 32'(rsp_valid), 32'd1);
            check($sformatf("b2b.ptr%0d", i), 32'(ptr), 32'(i % 16));
            check($sformatf("b2b.mem%0d", i), 32'({mem_ren, mem_wen}), 32'd0);
        end
        @(negedge clk);
        check("b2b.rsp_end", 32'(rsp_valid), 32'd0);
        check("b2b.ptr_end", 32'(ptr), 32'd1);
        @(posedge clk);
        #1;

        // Reset during MOD of CELL_INC aborts the write and the response
        apply_reset();
        cmd_valid = 1'b1;
        cmd_op    = OP_CELL_INC;
        @(negedge clk);
        check("abort.ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort.in_mod", 32'(state), 32'(ST_MOD));
        check("abort.wen_mod", 32'(mem_wen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort.state", 32'(state), 32'(ST_IDLE));
        check("abort.wen", 32'(mem_wen), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        g_core = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) g_core = 1'b1;
        end
        check("abort.no_rsp", 32'(g_core), 32'd0);
        check("abort.ptr", 32'(ptr), 32'd0);
        check("abort.mem0", 32'(mem[0]), 32'h22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
